// File: rtl/wb_lcd_hd44780.sv
// wb_lcd_hd44780 - Wishbone slave driving an HD44780 character LCD in 4-bit mode.
//
// The CPU pushes characters (DATA) and commands (CMD) into a small FIFO. An
// internal sequencer runs the HD44780 power-on init sequence. It then sends
// each FIFO entry as two nibbles, using setup, enable and execution timing.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   wb_adr_i[3:2]       register select: 0 DATA(w) 1 CMD(w) 2 STATUS(r/w) 3 reserved
//   wb_dat_i / wb_dat_o write data / registered read data (0 outside STATUS reads)
//   wb_stb_i, wb_cyc_i  Wishbone strobe / cycle
//   wb_we_i             write enable
//   wb_sel_i            byte select (ignored, full-word access)
//   wb_ack_o            single-cycle acknowledge, no wait states
//   lcd_rs, lcd_rw      register select (1 = data), read/write (always write)
//   lcd_e, lcd_d[3:0]   enable strobe and data nibble DB7..DB4
//
// STATUS: bit0 busy, bit1 full, bit2 init_done, bit3 overflow (sticky,
// cleared by writing STATUS with bit3 set), bits[7:4] FIFO count.
module wb_lcd_hd44780 #(
  parameter int clk_freq = 50000000,
  parameter int t_por_us = 15000,
  parameter int fifo_aw  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [3:0]  lcd_d
);

  // state     | meaning
  // POR_WAIT  | power-on delay before the first init nibble
  // IDLE      | init finished, waiting for a FIFO entry
  // SETUP     | rs/d driven, E low (1 us)
  // EN_HI     | E high (1 us)
  // EN_LO     | E low, rs/d still held (1 us)
  // EXEC_WAIT | post-nibble / post-byte execution delay
  typedef enum logic [2:0] {
    POR_WAIT, IDLE, SETUP, EN_HI, EN_LO, EXEC_WAIT
  } state_t;

  localparam int US = (clk_freq / 1000000 < 1) ? 1 : clk_freq / 1000000;
  localparam int PW = (US > 1) ? $clog2(US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(US - 1);
  localparam logic [13:0]   POR_US  = 14'(t_por_us);

  state_t state, state_nx;

  logic [PW-1:0] pre_cnt;
  logic [13:0]   us_cnt;
  logic [13:0]   load_us;
  logic [13:0]   wait_us;
  logic          tmr_load;
  logic          tmr_done;

  logic [2:0] init_idx;
  logic [2:0] init_idx_nx;
  logic       init_done;
  logic       cur_rs;
  logic [7:0] cur_byte;
  logic       single;
  logic       hi;

  logic [8:0]         mem [1 << fifo_aw];
  logic [fifo_aw-1:0] wr_ptr, rd_ptr;
  logic [fifo_aw:0]   count;
  logic               fifo_empty, fifo_full;
  logic [8:0]         fifo_head;
  logic               push_req, push_ok, pop;
  logic [8:0]         push_data;

  logic        wb_req;
  logic [1:0]  reg_sel;
  logic        ovf;
  logic        ovf_set, ovf_clr;
  logic [31:0] status;
  logic        sig_unused;

  assign sig_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

  // The init sequence is 0x3,0x3,0x3,0x2 as single high nibbles, then full bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h20;
      3'd4:             init_byte = 8'h28;
      3'd5:             init_byte = 8'h0C;
      3'd6:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  // ---------------- Wishbone ----------------
  assign wb_req    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign reg_sel   = wb_adr_i[3:2];
  assign push_req  = wb_req & wb_we_i & ~reg_sel[1];
  assign push_data = {~reg_sel[0], wb_dat_i[7:0]};
  assign push_ok   = push_req & (~fifo_full | pop);
  assign ovf_set   = push_req & fifo_full & ~pop;
  assign ovf_clr   = wb_req & wb_we_i & (reg_sel == 2'd2) & wb_dat_i[3];

  assign status = {24'd0, 4'(count), ovf, init_done, fifo_full,
                   (state != IDLE) | ~fifo_empty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      ovf      <= 1'b0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= (wb_req & ~wb_we_i & (reg_sel == 2'd2)) ? status : 32'd0;
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // ---------------- FIFO ----------------
  assign fifo_empty = (count == '0);
  assign fifo_full  = count[fifo_aw];
  assign fifo_head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, a simultaneous pop frees the slot being written; the pop
  // reads the old contents at the same edge.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  // ---------------- Microsecond timer ----------------
  // Every state change reloads the timer with the duration of the state
  // being entered. tmr_done flags the last cycle of that duration.
  always_comb begin
    wait_us = 14'd40;
    if (!init_done && !init_idx[2])
      wait_us = (init_idx == 3'd0) ? 14'd4100 : 14'd100;
    else if (!cur_rs && (cur_byte[7:2] == 6'd0))
      wait_us = 14'd1640;
  end

  always_comb begin
    case (state_nx)
      POR_WAIT:  load_us = POR_US;
      EXEC_WAIT: load_us = wait_us;
      default:   load_us = 14'd1;
    endcase
  end

  assign tmr_load = (state_nx != state);
  assign tmr_done = (pre_cnt == '0) && (us_cnt == 14'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= PRE_MAX;
      us_cnt  <= POR_US;
    end else if (tmr_load) begin
      pre_cnt <= PRE_MAX;
      us_cnt  <= load_us;
    end else if (pre_cnt == '0) begin
      pre_cnt <= PRE_MAX;
      if (us_cnt != 14'd0)
        us_cnt <= us_cnt - 14'd1;
    end else begin
      pre_cnt <= pre_cnt - 1'b1;
    end
  end

  // ---------------- Sequencer FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= POR_WAIT;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      POR_WAIT:  if (tmr_done) state_nx = SETUP;
      IDLE:      if (!fifo_empty) state_nx = SETUP;
      SETUP:     if (tmr_done) state_nx = EN_HI;
      EN_HI:     if (tmr_done) state_nx = EN_LO;
      EN_LO:     if (tmr_done) state_nx = (hi && !single) ? SETUP : EXEC_WAIT;
      EXEC_WAIT: if (tmr_done)
                   state_nx = (init_done || init_idx == 3'd7) ? IDLE : SETUP;
      default:   state_nx = POR_WAIT;
    endcase
  end

  always_comb begin
    lcd_e  = (state == EN_HI);
    lcd_rs = cur_rs;
    lcd_rw = 1'b0;
    lcd_d  = hi ? cur_byte[7:4] : cur_byte[3:0];
    pop    = (state == IDLE) && !fifo_empty;
  end

  // Transfer context: the byte in flight, which nibble is on the bus, and
  // the progress through the init sequence.
  assign init_idx_nx = init_idx + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_idx  <= 3'd0;
      init_done <= 1'b0;
      cur_rs    <= 1'b0;
      cur_byte  <= 8'd0;
      single    <= 1'b0;
      hi        <= 1'b1;
    end else begin
      case (state)
        POR_WAIT: if (tmr_done) begin
          init_idx <= 3'd0;
          cur_rs   <= 1'b0;
          cur_byte <= init_byte(3'd0);
          single   <= 1'b1;
          hi       <= 1'b1;
        end
        IDLE: if (!fifo_empty) begin
          cur_rs   <= fifo_head[8];
          cur_byte <= fifo_head[7:0];
          single   <= 1'b0;
          hi       <= 1'b1;
        end
        EN_LO: if (tmr_done && hi && !single) begin
          hi <= 1'b0;
        end
        EXEC_WAIT: if (tmr_done && !init_done) begin
          if (init_idx == 3'd7) begin
            init_done <= 1'b1;
          end else begin
            init_idx <= init_idx_nx;
            cur_rs   <= 1'b0;
            cur_byte <= init_byte(init_idx_nx);
            single   <= ~init_idx_nx[2];
            hi       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lcd_hd44780.sv
// Testbench for wb_lcd_hd44780: a scoreboard of expected LCD nibbles, with
// timing bounds derived from the HD44780 sequencing rules, checked against
// an E-pulse monitor.
module tb_wb_lcd_hd44780;

  localparam int CLK_FREQ = 4000000;
  localparam int T_POR    = 20;
  localparam int US       = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_ack_o;
  logic        lcd_rs, lcd_rw, lcd_e;
  logic [3:0]  lcd_d;

  wb_lcd_hd44780 #(.clk_freq(CLK_FREQ), .t_por_us(T_POR), .fifo_aw(3)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  int clk_cnt = 0;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
               tag, act, act, exp, exp, clk_cnt);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit       rs;
    bit [3:0] nib;
    bit       last;      // ends a single nibble or a byte: execution wait follows
    int       wait_us;
    int       push_cyc;
  } nib_t;

  nib_t exp_q[$];

  function automatic int exec_us(input bit rs, input bit [7:0] b);
    return (!rs && b < 8'd4) ? 1640 : 40;
  endfunction

  task automatic model_push_byte(input bit rs, input bit [7:0] b, input int pc);
    exp_q.push_back('{rs, b[7:4], 1'b0, 0, pc});
    exp_q.push_back('{rs, b[3:0], 1'b1, exec_us(rs, b), pc});
  endtask

  task automatic model_init();
    exp_q.push_back('{1'b0, 4'h3, 1'b1, 4100, clk_cnt});
    exp_q.push_back('{1'b0, 4'h3, 1'b1, 100, clk_cnt});
    exp_q.push_back('{1'b0, 4'h3, 1'b1, 100, clk_cnt});
    exp_q.push_back('{1'b0, 4'h2, 1'b1, 100, clk_cnt});
    model_push_byte(1'b0, 8'h28, clk_cnt);
    model_push_byte(1'b0, 8'h0C, clk_cnt);
    model_push_byte(1'b0, 8'h01, clk_cnt);
    model_push_byte(1'b0, 8'h06, clk_cnt);
  endtask

  // ---------------- E-pulse monitor ----------------
  int       rel_cyc = 0;
  int       n_fall = 0;
  int       last_fall = 0;

  initial begin
    bit       in_pulse = 0;
    bit       have_prev = 0;
    bit       first_rise = 1;
    int       rise_c = 0;
    int       prev_fall = 0;
    int       g, lo, hi;
    bit       rise_rs = 0;
    bit [3:0] rise_d = 0;
    logic     prev_rs = 0;
    logic [3:0] prev_d = 0;
    nib_t     cur, prev;
    cur  = '{0, 0, 0, 0, 0};
    prev = '{0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_pulse   = 0;
        have_prev  = 0;
        first_rise = 1;
      end else if (lcd_e && !in_pulse) begin
        in_pulse = 1;
        rise_c   = clk_cnt;
        rise_rs  = lcd_rs;
        rise_d   = lcd_d;
        chk_eq("setup_d", lcd_d, prev_d);
        chk_eq("setup_rs", lcd_rs, prev_rs);
        chk_eq("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk_eq("nibble_rs", lcd_rs, cur.rs);
          chk_eq("nibble_d", lcd_d, cur.nib);
          if (first_rise) begin
            g = rise_c - rel_cyc;
            chk_eq("por_gap", g, clamp(g, T_POR * US, T_POR * US + 10));
          end else if (have_prev) begin
            g = rise_c - prev_fall;
            if (!prev.last) begin
              lo = 2 * US;
              hi = 2 * US;
            end else begin
              lo = (2 + prev.wait_us) * US;
              hi = (cur.push_cyc < prev_fall) ? lo + 1 : 1 << 30;
            end
            chk_eq("nibble_gap", g, clamp(g, lo, hi));
          end
        end
        first_rise = 0;
      end else if (!lcd_e && in_pulse) begin
        in_pulse = 0;
        chk_eq("e_width", clk_cnt - rise_c, US);
        chk_eq("hold_d", lcd_d, rise_d);
        chk_eq("hold_rs", lcd_rs, rise_rs);
        prev      = cur;
        prev_fall = clk_cnt;
        have_prev = 1;
        last_fall = clk_cnt;
        n_fall++;
      end
      prev_rs = lcd_rs;
      prev_d  = lcd_d;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic [1:0] sel, input bit we, input logic [31:0] dat,
                         output logic [31:0] rd);
    @(negedge clk);
    wb_adr_i = {28'd0, sel, 2'b00};
    wb_dat_i = dat;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("ack_high", wb_ack_o, 1'b1);
    rd = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("ack_single", wb_ack_o, 1'b0);
  endtask

  task automatic wr_data(input bit [7:0] b, input bit accept);
    logic [31:0] rd;
    wb_xfer(2'd0, 1'b1, {24'd0, b}, rd);
    if (accept) model_push_byte(1'b1, b, clk_cnt);
  endtask

  task automatic wr_cmd(input bit [7:0] b);
    logic [31:0] rd;
    wb_xfer(2'd1, 1'b1, {24'd0, b}, rd);
    model_push_byte(1'b0, b, clk_cnt);
  endtask

  task automatic rd_status(output logic [31:0] v);
    wb_xfer(2'd2, 1'b0, 32'd0, v);
  endtask

  task automatic wait_idle(input int max_cyc);
    logic [31:0] v;
    int start;
    start = clk_cnt;
    rd_status(v);
    while (v[0] && (clk_cnt - start) < max_cyc)
      rd_status(v);
    chk_eq("idle_reached", v[0], 1'b0);
    chk_eq("model_drained", exp_q.size(), 0);
  endtask

  task automatic wait_falls(input int target, input int max_cyc);
    int k;
    k = 0;
    while (n_fall < target && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk_eq("falls_seen", n_fall >= target, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int f0, start, k, n;
    bit rs;
    bit [7:0] b;

    repeat (3) @(negedge clk);
    chk_eq("rst_ack", wb_ack_o, 1'b0);
    chk_eq("rst_dat", wb_dat_o, 32'd0);
    chk_eq("rst_e", lcd_e, 1'b0);
    chk_eq("rst_rs", lcd_rs, 1'b0);
    chk_eq("rst_rw", lcd_rw, 1'b0);
    chk_eq("rst_d", lcd_d, 4'd0);

    #2 rst = 1'b1;
    rel_cyc = clk_cnt;
    model_init();
    rd_status(v);
    chk_eq("status_por", v, 32'h01);
    wb_xfer(2'd3, 1'b0, 32'd0, v);
    chk_eq("reserved_read", v, 32'd0);
    wb_xfer(2'd0, 1'b0, 32'd0, v);
    chk_eq("data_read", v, 32'd0);
    wait_idle(40000);
    rd_status(v);
    chk_eq("status_init_done", v, 32'h04);

    // single character, busy window after the last E
    f0 = n_fall;
    wr_data(8'h41, 1'b1);
    wait_falls(f0 + 2, 500);
    start = last_fall;
    while (clk_cnt < start + 150) @(negedge clk);
    rd_status(v);
    chk_eq("busy_during_exec", v[0], 1'b1);
    while (clk_cnt < start + 175) @(negedge clk);
    rd_status(v);
    chk_eq("status_after_exec", v, 32'h04);

    // overflow: 9 pushes while the sequencer sits in its execution wait
    f0 = n_fall;
    wr_data(8'h60, 1'b1);
    wait_falls(f0 + 2, 500);
    for (int i = 0; i < 9; i++)
      wr_data(8'h61 + 8'(i), i < 8);
    rd_status(v);
    chk_eq("status_overflow", v, 32'h8F);
    wb_xfer(2'd2, 1'b1, 32'h8, v);
    rd_status(v);
    chk_eq("status_ovf_cleared", v, 32'h87);
    wait_idle(5000);

    // commands: clear/home long wait, others short
    wr_cmd(8'h02);
    wr_cmd(8'h80);
    wr_data(8'h55, 1'b1);
    wait_idle(10000);

    // reset in the middle of an E pulse
    wr_data(8'h31, 1'b1);
    wr_data(8'h32, 1'b1);
    k = 0;
    while (!lcd_e && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk_eq("e_seen", lcd_e, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_eq("rst_async_e", lcd_e, 1'b0);
    chk_eq("rst_async_d", lcd_d, 4'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    rel_cyc = clk_cnt;
    model_init();
    rd_status(v);
    chk_eq("status_fifo_cleared", v, 32'h01);
    wr_data(8'hA5, 1'b1);
    rd_status(v);
    chk_eq("status_push_in_por", v, 32'h11);
    wait_idle(40000);
    rd_status(v);
    chk_eq("status_reinit_done", v, 32'h04);

    // randomized bursts, each fitting in the FIFO
    for (int bu = 0; bu < 4; bu++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        rs = 1'($urandom_range(0, 1));
        if (rs) begin
          b = 8'($urandom_range(0, 255));
          wr_data(b, 1'b1);
        end else begin
          b = 8'($urandom_range(4, 255));
          wr_cmd(b);
        end
      end
      wait_idle(20000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
